// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP} state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  function automatic int baud_divider(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // A divider of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int divider);
    return (divider > 1) ? $clog2(divider) : 1;
  endfunction

endpackage

// File: rtl/uarttx_if.sv
// Byte handshake into the UART transmitter.
// A byte transfers on every rising clk edge where data_valid && ready; the
// master holds data_in and data_valid stable until that edge, and ready
// never depends combinationally on data_valid.
interface uarttx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick pulses on the last clock of every DIVIDER-clock bit,
// counter held at zero while clear is high.
module uart_baud_gen
  import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIVIDER = baud_divider(CLK_FREQ, BAUD);
    localparam int CW      = cnt_width(DIVIDER);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uarttx.sv
// UART transmitter, 8E1, double-buffered (hold + shift) for gap-free frames.
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
module uarttx
  import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic   clk,
    input  logic   reset,
`ifdef UART_TX_BREAK_EN
    input  logic   brk,
`endif
    uarttx_if.slave s_if,
    output logic   tx,
    output logic   busy,
    output state_t dbg_state
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] hold, shifter, shifter_n;
    logic                 hold_full;
    logic                 par, par_n;
    logic [2:0]           idx, idx_n;
    logic                 tick, baud_clear;
    logic                 load, accept, ready_i, tx_d;
    logic                 brk_i, brk_seen;

`ifdef UART_TX_BREAK_EN
    assign brk_i = brk;
`else
    assign brk_i = 1'b0;
`endif

    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // After a break is released, one idle-high STOP bit precedes any frame.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (brk_i)          state_n = IDLE;
                else if (brk_seen)  state_n = STOP;
                else if (hold_full) state_n = START;
            end
            START: if (tick) state_n = BITS;
            BITS:  if (tick && idx == LAST_BIT) state_n = PAR;
            PAR:   if (tick) state_n = STOP;
            STOP: begin
                if (tick) begin
                    if (brk_i)          state_n = IDLE;
                    else if (hold_full) state_n = START;
                    else                state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next-cycle values so it lines up with state.
    always_comb begin
        load      = (state_n == START) && (state != START);
        ready_i   = !hold_full && !(brk_i && state == IDLE);
        accept    = s_if.data_valid && ready_i;
        busy      = (state != IDLE);
        shifter_n = shifter;
        par_n     = par;
        idx_n     = idx;
        if (load) begin
            shifter_n = hold;
            par_n     = 1'b0;
            idx_n     = 3'd0;
        end else if (state == BITS && tick) begin
            par_n     = par ^ shifter[0];
            shifter_n = {1'b0, shifter[DATA_BITS-1:1]};
            idx_n     = idx + 3'd1;
        end
        case (state_n)
            IDLE:    tx_d = !brk_i;
            START:   tx_d = 1'b0;
            BITS:    tx_d = shifter_n[0];
            PAR:     tx_d = par_n;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx        <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            par       <= 1'b0;
            idx       <= 3'd0;
            brk_seen  <= 1'b0;
        end else begin
            tx <= tx_d;
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= s_if.data_in;
                hold_full <= 1'b1;
            end
            shifter  <= shifter_n;
            par      <= par_n;
            idx      <= idx_n;
            brk_seen <= (state == IDLE) ? (brk_seen | brk_i) : 1'b0;
        end
    end

    assign s_if.ready = ready_i;
    assign dbg_state  = state;

endmodule

// File: tb/tb_uarttx.sv
// Directed bench for uarttx: frame tables at DIVIDER=16, corner sequences,
// and a 115200-baud instance decoded by a bench-side receiver model.
module tb_uarttx;
  import uart_pkg::*;

  localparam int DIV    = 16;
  localparam int LB_DIV = 50_000_000 / 115200;

  logic   clk = 1'b0;
  logic   reset;
  logic   tx, busy, tx_lb, busy_lb;
  state_t st, st_lb;
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  logic [10:0] exp_q[$];

`ifdef UART_TX_BREAK_EN
  logic brk;
  logic brk_lb;
`endif

  uarttx_if m_if ();
  uarttx_if lb_if ();

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uarttx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef UART_TX_BREAK_EN
    .brk       (brk),
`endif
    .s_if      (m_if.slave),
    .tx        (tx),
    .busy      (busy),
    .dbg_state (st)
  );

  uarttx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut_lb (
    .clk       (clk),
    .reset     (reset),
`ifdef UART_TX_BREAK_EN
    .brk       (brk_lb),
`endif
    .s_if      (lb_if.slave),
    .tx        (tx_lb),
    .busy      (busy_lb),
    .dbg_state (st_lb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: offer one byte from a negedge, return the handshake cycle
  task automatic drive_byte(input bit lb, input logic [7:0] d, output int hs);
    int w;
    logic rdy;
    w  = 0;
    hs = -1;
    @(negedge clk);
    if (lb) begin lb_if.data_in = d; lb_if.data_valid = 1'b1; end
    else    begin m_if.data_in  = d; m_if.data_valid  = 1'b1; end
    #1;
    rdy = lb ? lb_if.ready : m_if.ready;
    while (!rdy && w < 30 * LB_DIV) begin
      @(negedge clk);
      w++;
      rdy = lb ? lb_if.ready : m_if.ready;
    end
    if (!rdy) begin
      check("handshake_timeout", 32'd1, 32'd0);
    end else begin
      hs = cyc;
      @(posedge clk);
    end
    #1;
    if (lb) lb_if.data_valid = 1'b0;
    else    m_if.data_valid  = 1'b0;
  endtask

  // receiver model: waits for a start bit, samples mid-bit, flags any
  // level change inside a bit and any busy-low sample inside the frame
  task automatic capture_frame(input bit lb, input int div, output logic [10:0] f,
                               output int fall, output int glitch, output int busy_lo,
                               output int pre_high);
    int   w;
    logic cur, prev;
    f = '0; fall = -1; glitch = 0; busy_lo = 0; w = 0;
    do begin
      @(negedge clk);
      w++;
      cur = lb ? tx_lb : tx;
    end while (cur !== 1'b0 && w < 30 * div);
    pre_high = w - 1;
    if (cur !== 1'b0) begin
      check("start_timeout", 32'd1, 32'd0);
      f = '1;
    end else begin
      fall = cyc;
      for (int b = 0; b < FRAME_BITS; b++) begin
        for (int s = 0; s < div; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          cur = lb ? tx_lb : tx;
          if (s == 0) prev = cur;
          else if (cur !== prev) glitch++;
          if (s == div / 2) f[b] = cur;
          if ((lb ? busy_lb : busy) !== 1'b1) busy_lo++;
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop
  } vec_t;

  vec_t vecs[7];
  int   hs, hs2, fall, fall2, gl, blo, pre, bad;
  logic [10:0] f, f2;

  initial begin
    vecs[0] = '{8'hA5, 11'h54A};
    vecs[1] = '{8'h07, 11'h60E};
    vecs[2] = '{8'h01, 11'h602};
    vecs[3] = '{8'h80, 11'h700};
    vecs[4] = '{8'h3C, 11'h478};
    vecs[5] = '{8'h00, 11'h400};
    vecs[6] = '{8'hFF, 11'h5FE};

    reset = 1'b1;
    m_if.data_valid = 1'b0;  m_if.data_in = '0;
    lb_if.data_valid = 1'b0; lb_if.data_in = '0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0; brk_lb = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_ready", m_if.ready, 1);
    check("reset_busy", busy, 0);
    check("reset_state", st, IDLE);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_tx", tx, 1);

    // table-driven single frames
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].frame);
      fork
        drive_byte(1'b0, vecs[i].data, hs);
        capture_frame(1'b0, DIV, f, fall, gl, blo, pre);
      join
      check($sformatf("frame_%02h", vecs[i].data), f, exp_q.pop_front());
      check($sformatf("latency_%02h", vecs[i].data), fall - hs, 2);
      check($sformatf("bit_width_%02h", vecs[i].data), gl, 0);
      check($sformatf("busy_frame_%02h", vecs[i].data), blo, 0);
      @(negedge clk);
      check($sformatf("busy_after_%02h", vecs[i].data), busy, 0);
      check($sformatf("tx_after_%02h", vecs[i].data), tx, 1);
    end

    // back-to-back with data_valid held high
    exp_q.push_back(11'h4AA);
    exp_q.push_back(11'h5FE);
    fork
      begin
        @(negedge clk);
        m_if.data_in = 8'h55; m_if.data_valid = 1'b1;
        bad = 0;
        #1;
        while (!m_if.ready && bad < 100) begin @(negedge clk); bad++; end
        hs = cyc;
        @(posedge clk); #1;
        m_if.data_in = 8'hFF;
        @(negedge clk);
        bad = 0;
        while (!m_if.ready && bad < 100) begin @(negedge clk); bad++; end
        hs2 = cyc;
        @(posedge clk); #1;
        m_if.data_valid = 1'b0;
        @(negedge clk);
        check("b2b_ready_low", m_if.ready, 0);
        repeat (167) @(negedge clk);
        check("b2b_ready_mid", m_if.ready, 0);
        repeat (7) @(negedge clk);
        check("b2b_ready_stop", m_if.ready, 0);
        @(negedge clk);
        check("b2b_ready_drain", m_if.ready, 1);
      end
      begin
        capture_frame(1'b0, DIV, f, fall, gl, blo, pre);
        capture_frame(1'b0, DIV, f2, fall2, bad, blo, pre);
      end
    join
    check("b2b_accept_gap", hs2 - hs, 2);
    check("b2b_frame1", f, exp_q.pop_front());
    check("b2b_frame2", f2, exp_q.pop_front());
    check("b2b_no_gap", fall2 - fall, 11 * DIV);
    @(negedge clk);
    check("b2b_idle", busy, 0);

    // reset in the middle of a frame with a second byte already held
    drive_byte(1'b0, 8'hA5, hs);
    @(negedge clk);
    check("load_state_idle", st, IDLE);
    check("load_ready_low", m_if.ready, 0);
    @(negedge clk);
    check("load_state_start", st, START);
    check("load_tx_low", tx, 0);
    drive_byte(1'b0, 8'h07, hs);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_ready", m_if.ready, 1);
    check("midreset_busy", busy, 0);
    check("midreset_state", st, IDLE);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midreset_quiet", bad, 0);

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    brk = 1'b1;
    #1;
    bad = (m_if.ready !== 1'b0) ? 1 : 0;
    repeat (99) begin
      @(negedge clk);
      if (tx !== 1'b0 || m_if.ready !== 1'b0) bad++;
    end
    check("break_window", bad, 0);
    @(negedge clk);
    brk = 1'b0;
    exp_q.push_back(11'h602);
    fork
      drive_byte(1'b0, 8'h01, hs);
      capture_frame(1'b0, DIV, f, fall, gl, blo, pre);
    join
    check("break_idle_ge16", (pre >= DIV) ? 1 : 0, 1);
    check("break_frame", f, exp_q.pop_front());
`endif

    // loopback at the production baud rate
    exp_q.push_back(11'h400);
    exp_q.push_back(11'h5FE);
    exp_q.push_back(11'h478);
    fork
      begin
        drive_byte(1'b1, 8'h00, hs);
        drive_byte(1'b1, 8'hFF, hs);
        drive_byte(1'b1, 8'h3C, hs);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          capture_frame(1'b1, LB_DIV, f, fall, gl, blo, pre);
          check($sformatf("loop_frame_%0d", k), f, exp_q.pop_front());
          check($sformatf("loop_width_%0d", k), gl, 0);
        end
      end
    join
    @(negedge clk);
    check("loop_idle", busy_lb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
